login_input_conditioner: RTL and testbench
==========================================

LOGIN_INPUT_CONDITIONER -- requirements
Module: login_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable synchronized cycles needed to accept a key level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter IDLE_CYCLES, default 1500000000, meaning the number of session cycles without key activity before an automatic logout.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port EnterKey_n, input, 1 bit: raw asynchronous pushbutton, active-low.
REQ-006 The block SHALL have port LogOutKey_n, input, 1 bit: raw asynchronous pushbutton, active-low.
REQ-007 The block SHALL have port SwitchesRaw, input, 4 bits: raw asynchronous slide switches.
REQ-008 The block SHALL have port SessionActive, input, 1 bit: high while a user is authenticated, driven from the authenticator's Successful output.
REQ-009 The block SHALL have port InputSwitches, output, 4 bits: synchronized switch value for ID and password entry.
REQ-010 The block SHALL have port EnterPswd, output, 1 bit: one-cycle pulse per accepted Enter press.
REQ-011 The block SHALL have port LogOutPulse, output, 1 bit: one-cycle pulse per accepted LogOut press or idle timeout.
REQ-012 The block SHALL have port IdleTimeout, output, 1 bit: one-cycle pulse, coincident with LogOutPulse, when the logout came from the idle timer.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer; key stages reset to 1 (released) and switch stages reset to 0.
REQ-014 InputSwitches SHALL equal the second synchronizer stage, giving 2-cycle latency with no debounce.
REQ-015 Each key SHALL have a debounce FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-016 In RELEASED, a synchronized low SHALL move the FSM to PRESS_WAIT with the counter cleared.
REQ-017 In PRESS_WAIT, the counter SHALL increment on each low cycle.
REQ-018 In PRESS_WAIT, a high cycle SHALL return the FSM to RELEASED with the counter cleared.
REQ-019 In PRESS_WAIT, a low cycle with counter == DEBOUNCE_CYCLES-1 SHALL move the FSM to PRESSED.
REQ-020 PRESSED SHALL handle a synchronized high symmetrically, going to RELEASE_WAIT.
REQ-021 RELEASE_WAIT SHALL handle its counter and bounce symmetrically, returning to PRESSED on a bounce and reaching RELEASED on a stable release.
REQ-022 The press strobe SHALL be asserted for exactly one cycle on the PRESS_WAIT->PRESSED transition only; a held key SHALL NOT repeat, and a release SHALL NOT produce a pulse.
REQ-023 A key held low continuously from raw cycle t SHALL produce its output pulse in cycle t+2+DEBOUNCE_CYCLES.
REQ-024 EnterPswd and LogOutPulse SHALL be registered outputs, never asserted together; if both strobes occur in the same cycle, LogOutPulse SHALL be emitted and that Enter press SHALL be discarded.
REQ-025 The idle counter SHALL increment each cycle while SessionActive=1, and SHALL clear while SessionActive=0 or in any cycle where EnterPswd or LogOutPulse is emitted.
REQ-026 When the idle counter == IDLE_CYCLES-1, LogOutPulse and IdleTimeout SHALL assert for one cycle and the counter SHALL clear.
REQ-027 If a key logout and an idle timeout coincide, a single LogOutPulse SHALL be emitted with IdleTimeout=0.
REQ-028 Counter widths SHALL be $clog2 of the respective parameter, with a minimum of 1 bit; counters SHALL saturate, never wrap.

Reset
REQ-029 On Reset=1 at a clock edge, both FSMs SHALL go to RELEASED and all counters SHALL clear.
REQ-030 On Reset=1 at a clock edge, EnterPswd, LogOutPulse and IdleTimeout SHALL go to 0 and InputSwitches SHALL go to 4'h0.
REQ-031 Reset asserted mid-debounce SHALL abort the debounce with no pulse emitted.
REQ-032 A key still held after Reset deasserts SHALL be treated as a new press and pulse after the full REQ-023 latency.

Structure
REQ-033 Package login_pkg SHALL hold the debounce state enum, the default DEBOUNCE_CYCLES and IDLE_CYCLES values, and the switch width constant (4).
REQ-034 Sub-module key_debouncer (synchronizer plus FSM plus press strobe) SHALL be instantiated twice; the priority logic and the idle timer SHALL live in the top level.

Verification (bench uses DEBOUNCE_CYCLES=4, IDLE_CYCLES=20)
REQ-035 The bench SHALL apply EnterKey_n low at cycle 10 and hold it, and SHALL check EnterPswd=1 only at cycle 16 and no repeat over 50 further cycles.
REQ-036 The bench SHALL apply EnterKey_n toggling every 2 cycles for 20 cycles and then high, and SHALL check that no EnterPswd occurs.
REQ-037 The bench SHALL drive both keys low at the same cycle and hold them, and SHALL check a single LogOutPulse at t+6, with EnterPswd=0 throughout.
REQ-038 The bench SHALL hold SessionActive=1 with no keys, and SHALL check LogOutPulse=IdleTimeout=1 at cycle 20 and again at cycle 40; an Enter pulse at cycle 30 SHALL push the second timeout to cycle 51.
REQ-039 The bench SHALL assert Reset for 1 cycle during PRESS_WAIT (key held), and SHALL check that all outputs are 0 and that a pulse follows 2+4 cycles after release of Reset.
REQ-040 The bench SHALL change SwitchesRaw from 4'h0 to 4'hA at cycle t, and SHALL check InputSwitches=4'hA from cycle t+2.

Source files
------------

// File: rtl/login_pkg.sv
`default_nettype none
// ============================================================================
// Module      : login_pkg
// Description : Shared types and constants for the login input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package login_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam int unsigned c_DEFAULT_DEBOUNCE_CYCLES = 32'd500000;
    localparam int unsigned c_DEFAULT_IDLE_CYCLES     = 32'd1500000000;
    localparam int unsigned c_SWITCH_W                = 32'd4;

    // Counter width for a terminal count of n cycles, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : 2-flop synchronizer, press/release debounce FSM, press strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
    import login_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned              c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]       c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic               r_sync1;
    logic               r_sync2;
    db_state_t          r_state;
    db_state_t          w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_CNT_W-1:0] w_cnt_sat;
    logic               w_low;

    assign w_low     = ~r_sync2;
    assign w_cnt_sat = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Key synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= RELEASED;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_press      = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_low) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_low) begin
                    w_state_next = RELEASED;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    o_press      = 1'b1;
                end else begin
                    w_cnt_next   = w_cnt_sat;
                end
            end
            PRESSED: begin
                if (!w_low) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_low) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = RELEASED;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_sat;
                end
            end
            default: begin
                w_state_next = RELEASED;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/login_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : login_input_conditioner
// Description : Key debounce, switch sync, Enter/LogOut priority, idle logout.
// Revision    : 1.0 - initial release
// ============================================================================
module login_input_conditioner
    import login_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned IDLE_CYCLES     = c_DEFAULT_IDLE_CYCLES
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  EnterKey_n,
    input  logic                  LogOutKey_n,
    input  logic [c_SWITCH_W-1:0] SwitchesRaw,
    input  logic                  SessionActive,
    output logic [c_SWITCH_W-1:0] InputSwitches,
    output logic                  EnterPswd,
    output logic                  LogOutPulse,
    output logic                  IdleTimeout
);

    localparam int unsigned         c_IDLE_W    = cnt_width(IDLE_CYCLES);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_CYCLES - 32'd1);

    logic [c_SWITCH_W-1:0] r_sw_meta;
    logic [c_SWITCH_W-1:0] r_sw_sync;
    logic                  r_enter;
    logic                  r_logout;
    logic                  r_idle_to;
    logic [c_IDLE_W-1:0]   r_idle_cnt;
    logic                  w_enter_press;
    logic                  w_logout_press;
    logic                  w_timeout;
    logic                  w_idle_clr;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk     (Clk),
        .rst     (Reset),
        .i_key_n (EnterKey_n),
        .o_press (w_enter_press)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_logout_db (
        .clk     (Clk),
        .rst     (Reset),
        .i_key_n (LogOutKey_n),
        .o_press (w_logout_press)
    );

    assign w_timeout  = SessionActive && (r_idle_cnt == c_IDLE_LAST);
    // A timeout already restarts the count when it fires, so its own LogOutPulse
    // cycle keeps counting; key-driven pulses restart it in the cycle they show.
    assign w_idle_clr = !SessionActive || w_timeout || r_enter || (r_logout && !r_idle_to);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_enter    <= 1'b0;
            r_logout   <= 1'b0;
            r_idle_to  <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_sw_meta  <= SwitchesRaw;
            r_sw_sync  <= r_sw_meta;
            r_logout   <= w_logout_press | w_timeout;
            r_idle_to  <= w_timeout & ~w_logout_press;
            r_enter    <= w_enter_press & ~(w_logout_press | w_timeout);
            if (w_idle_clr) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != '1) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign InputSwitches = r_sw_sync;
    assign EnterPswd     = r_enter;
    assign LogOutPulse   = r_logout;
    assign IdleTimeout   = r_idle_to;

endmodule
`default_nettype wire

// File: tb/tb_login_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_login_input_conditioner
// Description : Directed and random checks against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_login_input_conditioner;

    localparam int c_D = 4;
    localparam int c_I = 20;

    logic       Clk           = 1'b0;
    logic       Reset         = 1'b1;
    logic       EnterKey_n    = 1'b1;
    logic       LogOutKey_n   = 1'b1;
    logic [3:0] SwitchesRaw   = 4'h0;
    logic       SessionActive = 1'b0;
    logic [3:0] InputSwitches;
    logic       EnterPswd;
    logic       LogOutPulse;
    logic       IdleTimeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: delayed raw samples, accepted key level and disagreement run length.
    logic [3:0] m_sw_d1, m_sw_d2;
    logic       m_key_d1 [2];
    logic       m_key_d2 [2];
    logic       m_lvl    [2];
    int         m_run    [2];
    int         m_idle;
    logic       m_enter, m_logout, m_idle_to;

    always #5 Clk = ~Clk;

    login_input_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .IDLE_CYCLES     (c_I)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .EnterKey_n    (EnterKey_n),
        .LogOutKey_n   (LogOutKey_n),
        .SwitchesRaw   (SwitchesRaw),
        .SessionActive (SessionActive),
        .InputSwitches (InputSwitches),
        .EnterPswd     (EnterPswd),
        .LogOutPulse   (LogOutPulse),
        .IdleTimeout   (IdleTimeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // A key level is accepted after c_D+1 consecutive samples disagreeing with it.
    function automatic logic deb(input int k, input logic x_low);
        logic strobe;
        strobe = 1'b0;
        if (x_low != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == c_D + 1) begin
                m_lvl[k] = x_low;
                m_run[k] = 0;
                strobe   = x_low;
            end
        end else begin
            m_run[k] = 0;
        end
        return strobe;
    endfunction

    task automatic model_edge();
        logic se, sl, to, clr;
        logic [1:0] raw;
        if (Reset) begin
            m_sw_d1 = 4'h0;
            m_sw_d2 = 4'h0;
            for (int k = 0; k < 2; k++) begin
                m_key_d1[k] = 1'b1;
                m_key_d2[k] = 1'b1;
                m_lvl[k]    = 1'b0;
                m_run[k]    = 0;
            end
            m_idle    = 0;
            m_enter   = 1'b0;
            m_logout  = 1'b0;
            m_idle_to = 1'b0;
            return;
        end
        raw = {LogOutKey_n, EnterKey_n};
        se  = deb(0, ~m_key_d2[0]);
        sl  = deb(1, ~m_key_d2[1]);
        for (int k = 0; k < 2; k++) begin
            m_key_d2[k] = m_key_d1[k];
            m_key_d1[k] = raw[k];
        end
        m_sw_d2 = m_sw_d1;
        m_sw_d1 = SwitchesRaw;
        to  = SessionActive && (m_idle == c_I - 1);
        clr = !SessionActive || to || m_enter || (m_logout && !m_idle_to);
        m_idle    = clr ? 0 : m_idle + 1;
        m_logout  = sl || to;
        m_idle_to = to && !sl;
        m_enter   = se && !m_logout;
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        cyc++;
        #1;
        check_eq("switches", 32'(InputSwitches), 32'(m_sw_d2));
        check_eq("enter",    32'(EnterPswd),     32'(m_enter));
        check_eq("logout",   32'(LogOutPulse),   32'(m_logout));
        check_eq("idle",     32'(IdleTimeout),   32'(m_idle_to));
    endtask

    task automatic reset_dut();
        Reset         = 1'b1;
        EnterKey_n    = 1'b1;
        LogOutKey_n   = 1'b1;
        SessionActive = 1'b0;
        SwitchesRaw   = 4'h0;
        repeat (2) step();
        check_eq("rst_sw",     32'(InputSwitches), 32'd0);
        check_eq("rst_enter",  32'(EnterPswd),     32'd0);
        check_eq("rst_logout", 32'(LogOutPulse),   32'd0);
        check_eq("rst_idle",   32'(IdleTimeout),   32'd0);
        Reset = 1'b0;
    endtask

    initial begin
        int n_en, n_lo;

        // Held Enter: single pulse at cycle 16, no repeat for 50 cycles.
        reset_dut();
        n_en = 0;
        for (int k = 1; k <= 66; k++) begin
            EnterKey_n = (k >= 10) ? 1'b0 : 1'b1;
            step();
            if (EnterPswd) n_en++;
            if (k == 16) check_eq("hold_enter_at_16", 32'(EnterPswd), 32'd1);
        end
        check_eq("hold_enter_count", 32'(n_en), 32'd1);

        // Bouncing Enter never qualifies.
        reset_dut();
        n_en = 0;
        for (int k = 1; k <= 40; k++) begin
            EnterKey_n = (k <= 20) ? logic'(((k - 1) / 2) % 2) : 1'b1;
            step();
            if (EnterPswd) n_en++;
        end
        check_eq("bounce_enter_count", 32'(n_en), 32'd0);

        // Both keys together: LogOut wins at t+6, Enter discarded.
        reset_dut();
        n_en = 0;
        n_lo = 0;
        for (int k = 1; k <= 40; k++) begin
            EnterKey_n  = 1'b0;
            LogOutKey_n = 1'b0;
            step();
            if (EnterPswd) n_en++;
            if (LogOutPulse) n_lo++;
            if (k == 7) check_eq("both_logout_at_7", 32'(LogOutPulse), 32'd1);
        end
        check_eq("both_enter_count",  32'(n_en), 32'd0);
        check_eq("both_logout_count", 32'(n_lo), 32'd1);

        // Idle timeouts at 20 and 40.
        reset_dut();
        n_lo = 0;
        for (int k = 1; k <= 55; k++) begin
            SessionActive = 1'b1;
            step();
            if (LogOutPulse) n_lo++;
            if (k == 20 || k == 40) begin
                check_eq("idle_logout", 32'(LogOutPulse), 32'd1);
                check_eq("idle_flag",   32'(IdleTimeout), 32'd1);
            end
        end
        check_eq("idle_count", 32'(n_lo), 32'd2);

        // Enter pulse at 30 pushes the second timeout to 51.
        reset_dut();
        n_lo = 0;
        for (int k = 1; k <= 60; k++) begin
            SessionActive = 1'b1;
            EnterKey_n    = (k >= 24 && k <= 33) ? 1'b0 : 1'b1;
            step();
            if (LogOutPulse) n_lo++;
            if (k == 30) check_eq("idle_enter_at_30", 32'(EnterPswd), 32'd1);
            if (k == 51) check_eq("idle_pushed_51",   32'(IdleTimeout), 32'd1);
        end
        check_eq("idle_pushed_count", 32'(n_lo), 32'd2);

        // Key logout coinciding with timeout: one pulse, IdleTimeout low.
        reset_dut();
        for (int k = 1; k <= 25; k++) begin
            SessionActive = 1'b1;
            LogOutKey_n   = (k >= 14) ? 1'b0 : 1'b1;
            step();
            if (k == 20) begin
                check_eq("coinc_logout", 32'(LogOutPulse), 32'd1);
                check_eq("coinc_idle",   32'(IdleTimeout), 32'd0);
            end
        end

        // Reset mid-debounce aborts; held key pulses 6 cycles after release.
        reset_dut();
        n_en = 0;
        for (int k = 1; k <= 20; k++) begin
            EnterKey_n = 1'b0;
            Reset      = (k == 5);
            step();
            if (k < 12 && EnterPswd) n_en++;
            if (k == 5) begin
                check_eq("midrst_enter",  32'(EnterPswd),     32'd0);
                check_eq("midrst_logout", 32'(LogOutPulse),   32'd0);
                check_eq("midrst_idle",   32'(IdleTimeout),   32'd0);
                check_eq("midrst_sw",     32'(InputSwitches), 32'd0);
            end
            if (k == 12) check_eq("midrst_enter_at_12", 32'(EnterPswd), 32'd1);
        end
        check_eq("midrst_early_pulses", 32'(n_en), 32'd0);

        // Switch path latency.
        reset_dut();
        for (int k = 1; k <= 12; k++) begin
            SwitchesRaw = (k >= 5) ? 4'hA : 4'h0;
            step();
            if (k >= 7) check_eq("switch_a", 32'(InputSwitches), 32'hA);
        end

        // Random traffic against the model.
        reset_dut();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) EnterKey_n = ~EnterKey_n;
            if ($urandom_range(0, 4) == 0) LogOutKey_n = ~LogOutKey_n;
            if ($urandom_range(0, 9) == 0) SwitchesRaw = 4'($urandom);
            if ($urandom_range(0, 39) == 0) SessionActive = ~SessionActive;
            Reset = ($urandom_range(0, 199) == 0);
            step();
        end
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
